// File: rtl/serial_shift_unit.sv
// serial_shift_unit: multi-cycle SLL/SRL/SRA shifter that moves STEP bit positions per clock,
// with a Start/Busy/Done handshake. Result is held until the next accepted Start.
module serial_shift_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned STEP    = 1
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            Start,
    input  logic [XLEN-1:0] Src1,
    input  logic [XLEN-1:0] Src2,
    input  logic            funct3_2,
    input  logic            funct7_5,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    // One extra bit so that STEP == XLEN is representable in the comparison.
    localparam int unsigned KW = SHAMT_W + 1;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_BAD = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [XLEN-1:0]     work_q;
    logic [SHAMT_W-1:0]  cnt_q;
    logic [1:0]          op_q;
    logic                busy_q;
    logic                done_q;

    logic [1:0]          start_op;
    logic [SHAMT_W-1:0]  start_shamt;
    logic [KW-1:0]       cnt_ext;
    logic [KW-1:0]       step_k;
    logic [SHAMT_W-1:0]  cnt_d;
    logic [XLEN-1:0]     work_d;

    // Only the low SHAMT_W bits of the shift amount are architecturally meaningful.
    logic                unused_src2_hi;
    assign unused_src2_hi = ^Src2[XLEN-1:SHAMT_W];

    assign start_op    = {funct7_5, funct3_2};
    assign start_shamt = Src2[SHAMT_W-1:0];

    // Per-cycle step: k = min(STEP, count), then apply it to the working register.
    always_comb begin
        cnt_ext = {1'b0, cnt_q};
        step_k  = (cnt_ext < KW'(STEP)) ? cnt_ext : KW'(STEP);
        cnt_d   = cnt_q - SHAMT_W'(step_k);
        work_d  = work_q;
        case (op_q)
            OP_SLL:  work_d = work_q << step_k;
            OP_SRL:  work_d = work_q >> step_k;
            OP_SRA:  work_d = $signed(work_q) >>> step_k;
            default: work_d = '0;
        endcase
    end

    // Control FSM with registered Busy/Done and the working register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_SLL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        op_q   <= start_op;
                        cnt_q  <= start_shamt;
                        busy_q <= 1'b1;
                        if (start_op == OP_BAD) begin
                            work_q  <= '0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (start_shamt == '0) begin
                            work_q  <= Src1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            work_q  <= Src1;
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_d;
                    if (cnt_d == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = work_q;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Testbench for serial_shift_unit: STEP=1 and STEP=4 instances driven in lockstep,
// checked against table constants and an arithmetic reference model.
module tb_serial_shift_unit;

    logic        CLK;
    logic        rst;
    logic        Start;
    logic [31:0] Src1;
    logic [31:0] Src2;
    logic        funct3_2;
    logic        funct7_5;
    logic        busy1, done1, busy4, done4;
    logic [31:0] res1, res4;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_shift_unit #(.XLEN(32), .SHAMT_W(5), .STEP(1)) u_dut1 (
        .CLK(CLK), .rst(rst), .Start(Start), .Src1(Src1), .Src2(Src2),
        .funct3_2(funct3_2), .funct7_5(funct7_5),
        .Busy(busy1), .Done(done1), .Result(res1)
    );

    serial_shift_unit #(.XLEN(32), .SHAMT_W(5), .STEP(4)) u_dut4 (
        .CLK(CLK), .rst(rst), .Start(Start), .Src1(Src1), .Src2(Src2),
        .funct3_2(funct3_2), .funct7_5(funct7_5),
        .Busy(busy4), .Done(done4), .Result(res4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic        f7;
        logic        f3;
        logic [31:0] res;
        int          l1;
        int          l4;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: shift amount is Src2 mod 32, op from {funct7_5, funct3_2}.
    function automatic logic [31:0] ref_result(input logic [31:0] s1, input logic [31:0] s2,
                                               input logic f7, input logic f3);
        int sh;
        logic [31:0] fill;
        sh = int'(s2 % 32);
        fill = (32'hFFFF_FFFF >> sh);
        case ({f7, f3})
            2'b00:   return s1 << sh;
            2'b01:   return s1 >> sh;
            2'b11:   return s1[31] ? ((s1 >> sh) | ~fill) : (s1 >> sh);
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [31:0] s2, input logic f7, input logic f3,
                                   input int step);
        int sh;
        sh = int'(s2 % 32);
        if ((f7 && !f3) || sh == 0) return 1;
        return (sh + step - 1) / step + 1;
    endfunction

    // Launch one op and observe both DUTs until one cycle past the later Done.
    // With harass set, Start is re-pulsed with junk operands through the earlier Done cycle.
    task automatic run_op(input string tag, input logic [31:0] s1, input logic [31:0] s2,
                          input logic f7, input logic f3, input bit harass,
                          input logic [31:0] exp_res, input int l1, input int l4);
        int maxl, minl;
        int dc1, dn1, bc1, dc4, dn4, bc4;
        logic [31:0] rd1, rd4, ra1, ra4;
        maxl = (l1 > l4) ? l1 : l4;
        minl = (l1 < l4) ? l1 : l4;
        dc1 = 0; dn1 = 0; bc1 = 0; dc4 = 0; dn4 = 0; bc4 = 0;
        rd1 = 32'hx; rd4 = 32'hx; ra1 = 32'hx; ra4 = 32'hx;
        Start = 1'b1; Src1 = s1; Src2 = s2; funct7_5 = f7; funct3_2 = f3;
        for (int c = 1; c <= maxl + 1; c++) begin
            @(negedge CLK);
            if (done1) begin dn1++; if (dc1 == 0) begin dc1 = c; rd1 = res1; end end
            if (done4) begin dn4++; if (dc4 == 0) begin dc4 = c; rd4 = res4; end end
            if (busy1) bc1++;
            if (busy4) bc4++;
            if (c == maxl + 1) begin ra1 = res1; ra4 = res4; end
            Src1 = $urandom; Src2 = $urandom;
            funct7_5 = 1'($urandom_range(0, 1));
            funct3_2 = 1'($urandom_range(0, 1));
            Start = harass && (c <= minl);
        end
        Start = 1'b0;
        check({tag, " s1 done_cycle"}, 32'(dc1), 32'(l1));
        check({tag, " s1 done_count"}, 32'(dn1), 32'd1);
        check({tag, " s1 busy_cycles"}, 32'(bc1), 32'(l1));
        check({tag, " s1 result_at_done"}, rd1, exp_res);
        check({tag, " s1 result_held"}, ra1, exp_res);
        check({tag, " s4 done_cycle"}, 32'(dc4), 32'(l4));
        check({tag, " s4 done_count"}, 32'(dn4), 32'd1);
        check({tag, " s4 busy_cycles"}, 32'(bc4), 32'(l4));
        check({tag, " s4 result_at_done"}, rd4, exp_res);
        check({tag, " s4 result_held"}, ra4, exp_res);
    endtask

    initial begin
        vec_t vecs[12];
        int dn, bc;
        logic [31:0] s1, s2;
        logic f7, f3;

        vecs[0]  = '{32'h0000_0001, 32'd31,        1'b0, 1'b0, 32'h8000_0000, 32, 9};
        vecs[1]  = '{32'h8000_0000, 32'h0000_0024, 1'b1, 1'b1, 32'hF800_0000, 5,  2};
        vecs[2]  = '{32'h8000_0000, 32'h0000_0024, 1'b0, 1'b1, 32'h0800_0000, 5,  2};
        vecs[3]  = '{32'hFFFF_FFFF, 32'd7,         1'b0, 1'b1, 32'h01FF_FFFF, 8,  3};
        vecs[4]  = '{32'hDEAD_BEEF, 32'd0,         1'b0, 1'b0, 32'hDEAD_BEEF, 1,  1};
        vecs[5]  = '{32'hCAFE_F00D, 32'h0000_0020, 1'b0, 1'b1, 32'hCAFE_F00D, 1,  1};
        vecs[6]  = '{32'h8000_0001, 32'hFFFF_FFE0, 1'b1, 1'b1, 32'h8000_0001, 1,  1};
        vecs[7]  = '{32'h1234_5678, 32'd5,         1'b1, 1'b0, 32'h0000_0000, 1,  1};
        vecs[8]  = '{32'h8000_0000, 32'd31,        1'b1, 1'b1, 32'hFFFF_FFFF, 32, 9};
        vecs[9]  = '{32'h7FFF_FFFF, 32'd8,         1'b1, 1'b1, 32'h007F_FFFF, 9,  3};
        vecs[10] = '{32'h1234_5678, 32'h0000_0104, 1'b0, 1'b0, 32'h2345_6780, 5,  2};
        vecs[11] = '{32'h8000_0000, 32'd16,        1'b0, 1'b1, 32'h0000_8000, 17, 5};

        rst = 1'b1; Start = 1'b0; Src1 = 32'hFFFF_FFFF; Src2 = 32'd3;
        funct3_2 = 1'b0; funct7_5 = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset s1 busy", 32'(busy1), 32'd0);
        check("reset s1 done", 32'(done1), 32'd0);
        check("reset s1 result", res1, 32'd0);
        check("reset s4 busy", 32'(busy4), 32'd0);
        check("reset s4 done", 32'(done4), 32'd0);
        check("reset s4 result", res4, 32'd0);
        rst = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].s1, vecs[i].s2, vecs[i].f7, vecs[i].f3,
                   1'b0, vecs[i].res, vecs[i].l1, vecs[i].l4);

        // Start pulsed while Busy and in the Done cycle, then accepted the cycle after.
        run_op("harass_sll1", 32'h0000_00F1, 32'd1, 1'b0, 1'b0, 1'b1, 32'h0000_01E2, 2, 2);
        run_op("after_harass", 32'h0000_ABCD, 32'd3, 1'b0, 1'b1, 1'b0, 32'h0000_1579, 4, 2);
        run_op("harass_zero", 32'h5A5A_5A5A, 32'd0, 1'b1, 1'b1, 1'b1, 32'h5A5A_5A5A, 1, 1);
        run_op("harass_bad", 32'h1234_5678, 32'd9, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1, 1);

        for (int i = 0; i < 24; i++) begin
            s1 = $urandom; s2 = $urandom;
            f7 = 1'($urandom_range(0, 1));
            f3 = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), s1, s2, f7, f3, 1'($urandom_range(0, 1)),
                   ref_result(s1, s2, f7, f3), ref_lat(s2, f7, f3, 1), ref_lat(s2, f7, f3, 4));
        end

        // Reset during SHIFT of a 20-bit shift aborts the operation.
        Start = 1'b1; Src1 = 32'h0000_0001; Src2 = 32'd20; funct7_5 = 1'b0; funct3_2 = 1'b0;
        @(negedge CLK);
        Start = 1'b0;
        repeat (4) @(negedge CLK);
        check("midop s1 busy_before_reset", 32'(busy1), 32'd1);
        check("midop s4 busy_before_reset", 32'(busy4), 32'd1);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        check("abort s1 busy", 32'(busy1), 32'd0);
        check("abort s1 done", 32'(done1), 32'd0);
        check("abort s1 result", res1, 32'd0);
        check("abort s4 busy", 32'(busy4), 32'd0);
        check("abort s4 done", 32'(done4), 32'd0);
        check("abort s4 result", res4, 32'd0);
        dn = 0; bc = 0;
        repeat (30) begin
            @(negedge CLK);
            if (done1 || done4) dn++;
            if (busy1 || busy4) bc++;
        end
        check("abort no_late_done", 32'(dn), 32'd0);
        check("abort stays_idle", 32'(bc), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_shift_unit.md
# serial_shift_unit

Multi-cycle, low-area shifter for the integer execute stage. It implements the same SLL/SRL/SRA operations and funct encoding as the combinational shift unit, but walks the operand `STEP` bit positions per clock. It uses a Start/Busy/Done handshake, so the core can select it in area-constrained builds or run it alongside other execute units. The result is registered and held until the next accepted Start.

## Interface
- `XLEN`, 32: operand/result width.
- `SHAMT_W`, 5: shift-amount width, equal to log2(XLEN).
- `STEP`, 1: bit positions shifted per cycle. Power of two, 1..XLEN.

Ports:
- `CLK` input 1: clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `Start` input 1: request; sampled only when `Busy`=0.
- `Src1` input XLEN: operand to shift, treated as signed for SRA.
- `Src2` input XLEN: shift amount; only `Src2[SHAMT_W-1:0]` is used.
- `funct3_2` input 1: instruction funct3[2].
- `funct7_5` input 1: instruction funct7[5].
- `Busy` output 1: high from the cycle after an accepted Start through the Done cycle.
- `Done` output 1: one-cycle pulse; `Result` is valid in this cycle.
- `Result` output XLEN: shifted value, held after Done until the next accepted Start.

## Operation
- Op select uses {funct7_5, funct3_2}:
  - 00 = SLL.
  - 01 = SRL, zero fill.
  - 11 = SRA, fill with bit XLEN-1 of the captured operand.
  - 10 = invalid.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - On Start, capture Src1 into the working register, shamt = Src2[SHAMT_W-1:0] into the down-counter, and the op.
  - If the op is invalid, load the working register with 0 and go to DONE.
  - Else if shamt=0, go to DONE with the operand unchanged.
  - Else go to SHIFT.
- SHIFT:
  - Each cycle, shift the working register by k = min(STEP, count) and set count -= k.
  - When the new count is 0, go to DONE.
- DONE:
  - `Done`=1 for exactly one cycle, then return to IDLE.
- `Result` is the working register itself. It changes during SHIFT, so it is meaningful only when Done=1 and afterwards in IDLE.
- `Busy` = (state != IDLE). A Start while Busy is ignored and not queued.
- A Start in the same cycle as Done is ignored, because Busy is still 1 in that cycle. A new Start is first accepted the following cycle.
- Width rules:
  - Shift amounts are modulo XLEN through the SHAMT_W truncation.
  - Upper Src2 bits never affect the result.
  - The counter is SHAMT_W bits wide and never underflows.

## Timing
- Reset values: state=IDLE, `Result`=0, `Busy`=0, `Done`=0, counter=0.
- Reset dominates Start and every state transition.
- Reset mid-operation aborts the operation. From the next cycle, all outputs show their reset values and no Done pulse is produced for the aborted operation.
- Latency, with Start accepted at edge k:
  - n = ceil(shamt/STEP) is the number of SHIFT cycles.
  - `Done` is high in cycle k+1+n; the first cycle after edge k is k+1.
  - shamt=0 or an invalid op gives `Done` in cycle k+1.
- Throughput: one operation per n+2 cycles, since IDLE lasts at least one cycle between operations.
- `Busy` rises in cycle k+1 and falls in the cycle after Done.
- Operand inputs are not used after edge k and may change freely while Busy.

## Test plan
- STEP=1, SLL, Src1=0x00000001, Src2=31 → Done in cycle k+32, Result=0x80000000, Busy high 32 cycles.
- STEP=1, SRA, Src1=0x80000000, Src2=0x00000024 (effective shamt 4) → Result=0xF8000000, Done in cycle k+5. Same stimulus with SRL → Result=0x08000000.
- STEP=4, SRL, Src1=0xFFFFFFFF, Src2=7 → two SHIFT cycles (4, then 3), Done in cycle k+3, Result=0x01FFFFFF.
- Src2=0 with each valid op → Done in cycle k+1, Result=Src1. Op 10 with Src1=0x12345678 → Done in cycle k+1, Result=0.
- Start with changed operands pulsed while Busy and in the Done cycle → no effect on the in-flight result, exactly one Done. A Start the next cycle is accepted.
- Reset asserted during SHIFT of a 20-bit shift → next cycle Busy=0, Done=0, Result=0, and no later Done pulse.
